// File: rtl/axi_sram_responder.sv
// axi_sram_responder: AXI-style burst responder backed by a single-port
// synchronous word RAM. It handles AW/W/B and AR/R bursts one at a time
// through a single FSM. When both address channels are valid, the
// granted channel alternates between write and read.
// Optional feature macro: AXI_RESPONDER_STALL_EN. When it is defined,
// wready is gated by a free-running toggle, and rvalid drops for one
// cycle after every R handshake.
module axi_sram_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 'h4000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           awaddr,
  input  logic [7:0]            awlen,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [31:0]           araddr,
  input  logic [7:0]            arlen,
  input  logic                  arvalid,
  output logic                  arready,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  protocol_error
);

  localparam int IDX_W     = $clog2(MEM_SIZE);
  localparam int BYTE_BITS = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, WRITE, WRITE_RESP, READ} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic [IDX_W-1:0]      idx_q;        // current word index, shared by both burst types
  logic [8:0]            cnt_q;        // beats left to transfer (write) or to fetch (read)
  logic                  prefer_read_q;
  logic                  w_gate;       // wready qualifier
  logic                  r_issue_ok;   // output stage can accept a new RAM read
  logic                  r_issue;
  logic                  w_hs;
  logic                  last_beat;
  logic                  addr_unused;

  // The upper address bits lie beyond the RAM and are ignored on purpose.
  assign addr_unused = ^{awaddr, araddr};

  assign w_hs      = wvalid && wready;
  assign last_beat = (cnt_q == 9'd1);

`ifdef AXI_RESPONDER_STALL_EN
  logic toggle_q;

  // Free-running toggle that throttles the write data channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) toggle_q <= 1'b0;
    else          toggle_q <= ~toggle_q;
  end

  assign w_gate     = toggle_q;
  assign r_issue_ok = !rvalid;  // a handshake forces a one-cycle rvalid bubble
`else
  assign w_gate     = 1'b1;
  assign r_issue_ok = !rvalid || rready;  // refill in the same cycle as a handshake
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic, channel readies and RAM read issue.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    awready = 1'b0;
    arready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    r_issue = 1'b0;
    case (state_q)
      IDLE: begin
        // The reset_n term keeps the readies low while reset is asserted.
        awready = reset_n && awvalid && (!arvalid || !prefer_read_q);
        arready = reset_n && arvalid && (!awvalid || prefer_read_q);
        if (awready)      state_d = WRITE;
        else if (arready) state_d = READ;
      end
      WRITE: begin
        wready = w_gate;
        if (wvalid && w_gate && last_beat) state_d = WRITE_RESP;
      end
      WRITE_RESP: begin
        bvalid = 1'b1;
        if (bready) state_d = IDLE;
      end
      READ: begin
        r_issue = (cnt_q != 9'd0) && r_issue_ok;
        if (rvalid && rready && (cnt_q == 9'd0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst bookkeeping, read output stage and sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q          <= '0;
      cnt_q          <= '0;
      prefer_read_q  <= 1'b0;
      rvalid         <= 1'b0;
      rdata          <= '0;
      protocol_error <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
      if (awready) begin
        idx_q         <= awaddr[BYTE_BITS +: IDX_W];
        cnt_q         <= {1'b0, awlen} + 9'd1;
        prefer_read_q <= 1'b1;
      end else if (arready) begin
        idx_q         <= araddr[BYTE_BITS +: IDX_W];
        cnt_q         <= {1'b0, arlen} + 9'd1;
        prefer_read_q <= 1'b0;
      end else if (w_hs) begin
        idx_q <= idx_q + 1'b1;
        cnt_q <= cnt_q - 9'd1;
        if (wlast != last_beat) protocol_error <= 1'b1;
      end else if (r_issue) begin
        idx_q <= idx_q + 1'b1;
        cnt_q <= cnt_q - 9'd1;
      end

      // rdata is the RAM's registered output. It only loads when the
      // consumer has taken the previous beat, so it also acts as the
      // holding register during a stall.
      if (r_issue) begin
        rdata  <= mem[idx_q];
        rvalid <= 1'b1;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // RAM write port.
  // NOTE: the RAM array has no reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (w_hs) mem[idx_q] <= wdata;
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder in its default, full-rate build.
module tb_axi_sram_responder;

  logic        clk;
  logic        reset_n;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, protocol_error;
  logic [31:0] wdata, rdata;

  int tests = 0;
  int fails = 0;

  axi_sram_responder #(.DATA_WIDTH(32), .MEM_SIZE('h4000)) dut (
    .clk(clk), .reset_n(reset_n),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .protocol_error(protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] wrap_exp [4];
    int k;
    wrap_exp = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};

    reset_n = 1'b0; awaddr = '0; awlen = '0; awvalid = 1'b0; wdata = '0;
    wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; araddr = '0; arlen = '0;
    arvalid = 1'b0; rready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_perr", protocol_error, 0);

    // Both address channels valid from reset: the write wins.
    next_cycle();
    reset_n = 1'b1;
    awaddr = 32'h100; awlen = 8'd3; awvalid = 1'b1;
    araddr = 32'h100; arlen = 8'd3; arvalid = 1'b1;
    @(negedge clk);
    check("arb1_awready", awready, 1);
    check("arb1_arready", arready, 0);

    next_cycle();
    awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wvalid = 1'b1; wdata = i + 1; wlast = (i == 3);
      @(negedge clk);
      check("w1_wready", wready, 1);
      check("w1_arready_blocked", arready, 0);
      check("w1_bvalid_low", bvalid, 0);
      next_cycle();
    end
    // Response cycle. The next write (at word MEM_SIZE-2) is queued alongside the pending read.
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    awaddr = 32'hFFF8; awlen = 8'd3; awvalid = 1'b1;
    @(negedge clk);
    check("w1_bvalid", bvalid, 1);
    check("w1_perr", protocol_error, 0);
    check("w1_awready_in_resp", awready, 0);

    // Back in IDLE with both valid: now the read wins.
    next_cycle();
    bready = 1'b0;
    @(negedge clk);
    check("arb2_arready", arready, 1);
    check("arb2_awready", awready, 0);

    next_cycle();
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    check("r1_latency_rvalid", rvalid, 0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      check("r1_rvalid", rvalid, 1);
      check("r1_rdata", rdata, i + 1);
      check("r1_awready_blocked", awready, 0);
    end

    // Back in IDLE with both valid again: the write wins (alternation).
    next_cycle();
    rready = 1'b0;
    araddr = 32'h100; arlen = 8'd3; arvalid = 1'b1;
    @(negedge clk);
    check("r1_done_rvalid", rvalid, 0);
    check("arb3_awready", awready, 1);
    check("arb3_arready", arready, 0);

    // Wrapping write with wlast on beat 2 only.
    next_cycle();
    awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wvalid = 1'b1; wdata = 32'hA0 + i; wlast = (i == 1);
      @(negedge clk);
      check("w2_wready", wready, 1);
      check("w2_perr", protocol_error, (i >= 2) ? 1 : 0);
      next_cycle();
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    @(negedge clk);
    check("w2_bvalid", bvalid, 1);
    check("w2_perr_sticky", protocol_error, 1);

    next_cycle();
    bready = 1'b0;
    @(negedge clk);
    check("arb4_arready", arready, 1);

    // Read of 'h100 with rready toggling every cycle.
    next_cycle();
    arvalid = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      rready = (c % 2 == 0);
      @(negedge clk);
      if (c == 0) check("r2_latency_rvalid", rvalid, 0);
      if (c == 1) check("r2_first_rvalid", rvalid, 1);
      if (rvalid) begin
        check("r2_rdata", rdata, k + 1);
        if (rready) k++;
      end
      next_cycle();
    end
    check("r2_beats", k, 4);
    rready = 1'b1;
    araddr = 32'hFFF8; arlen = 8'd3; arvalid = 1'b1;
    @(negedge clk);
    check("r2_done_rvalid", rvalid, 0);
    check("r3_arready", arready, 1);

    // Read back the wrapped region: words MEM_SIZE-2, MEM_SIZE-1, 0, 1.
    next_cycle();
    arvalid = 1'b0;
    @(negedge clk);
    check("r3_latency_rvalid", rvalid, 0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      check("r3_rvalid", rvalid, 1);
      check("r3_rdata", rdata, wrap_exp[i]);
    end
    next_cycle();
    araddr = 32'h100; arlen = 8'd3; arvalid = 1'b1;
    @(negedge clk);
    check("r3_done_rvalid", rvalid, 0);
    check("perr_still_set", protocol_error, 1);
    check("r4_arready", arready, 1);

    // Reset in the middle of a read burst.
    next_cycle();
    arvalid = 1'b0;
    next_cycle();
    @(negedge clk);
    check("r4_rdata0", rdata, 1);
    next_cycle();
    arvalid = 1'b1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_arready", arready, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_perr", protocol_error, 0);

    // Fresh read from IDLE after reset: words 0 and 1.
    next_cycle();
    reset_n = 1'b1;
    araddr = 32'h0; arlen = 8'd1; arvalid = 1'b1;
    @(negedge clk);
    check("r5_arready", arready, 1);
    next_cycle();
    arvalid = 1'b0;
    @(negedge clk);
    check("r5_latency_rvalid", rvalid, 0);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      check("r5_rvalid", rvalid, 1);
      check("r5_rdata", rdata, wrap_exp[i + 2]);
    end
    next_cycle();
    @(negedge clk);
    check("r5_done_rvalid", rvalid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
